// File: rtl/qpsk_deframer.sv
// qpsk_deframer: receive-side frame parser behind qpsk_demodulator.
// Hunts for SYNC_WORD in the 2-bit symbol stream (LSB pair first), reads a
// length byte, re-assembles payload bytes and reports frame status.
// Build option: define QPSK_DEFRAMER_CHK_EN to expect and verify a trailing
// XOR checksum byte; without it frames end after the last payload byte and
// frame_err_o is tied low.
module qpsk_deframer #(
    parameter logic [15:0] SYNC_WORD = 16'hD391,
    parameter int unsigned SYNC_SYMS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] data_i,
    input  logic       sym_valid_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       sof_o,
    output logic       eof_o,
    output logic [7:0] len_o,
    output logic       locked_o,
    output logic       frame_ok_o,
    output logic       frame_err_o
);

    localparam logic [3:0] LP_SYNC_SYMS = 4'(SYNC_SYMS);

`ifdef QPSK_DEFRAMER_CHK_EN
    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD
    } state_t;
`endif

    // Registered state
    state_t      r_state;
    logic [13:0] r_sr_hist;   // last 7 symbols; older bits can never be compared again
    logic [3:0]  r_hunt_cnt;  // valid symbols since entering HUNT, saturating
    logic [1:0]  r_sym_cnt;   // symbol position within the current byte
    logic [7:0]  r_asm;       // partially assembled byte
    logic [7:0]  r_idx;       // payload byte index
    logic [7:0]  r_csum;      // running XOR of payload bytes
    logic [7:0]  r_byte;
    logic        r_bv;
    logic        r_sof;
    logic        r_eof;
    logic [7:0]  r_len;
    logic        r_ok;
    logic        r_err;

    // Next-state values
    state_t      w_state;
    logic [13:0] w_sr_hist;
    logic [3:0]  w_hunt_cnt;
    logic [1:0]  w_sym_cnt;
    logic [7:0]  w_asm;
    logic [7:0]  w_idx;
    logic [7:0]  w_csum;
    logic [7:0]  w_byte;
    logic        w_bv;
    logic        w_sof;
    logic        w_eof;
    logic [7:0]  w_len;
    logic        w_ok;
    logic        w_err;

    // Helpers
    logic [15:0] w_sr_shift;
    logic [7:0]  w_asm_full;
    logic        w_last_sym;
    logic        w_last_byte;

    // Datapath helpers: shifted sync window and byte with the current symbol placed
    always_comb begin
        w_sr_shift  = {data_i, r_sr_hist};
        w_asm_full  = r_asm;
        w_asm_full[{r_sym_cnt, 1'b0} +: 2] = data_i;
        w_last_sym  = (r_sym_cnt == 2'd3);
        w_last_byte = (r_idx == 8'(r_len - 8'd1));
    end

    // Next-state and registered-output logic
    always_comb begin
        w_state    = r_state;
        w_sr_hist  = r_sr_hist;
        w_hunt_cnt = r_hunt_cnt;
        w_sym_cnt  = r_sym_cnt;
        w_asm      = r_asm;
        w_idx      = r_idx;
        w_csum     = r_csum;
        w_byte     = r_byte;
        w_len      = r_len;
        w_bv       = 1'b0;
        w_sof      = 1'b0;
        w_eof      = 1'b0;
        w_ok       = 1'b0;
        w_err      = 1'b0;

        if (sym_valid_i) begin
            case (r_state)
                ST_HUNT: begin
                    w_sr_hist = w_sr_shift[15:2];
                    if (r_hunt_cnt != LP_SYNC_SYMS) begin
                        w_hunt_cnt = r_hunt_cnt + 4'd1;
                    end
                    if ((w_sr_shift == SYNC_WORD) &&
                        (r_hunt_cnt >= (LP_SYNC_SYMS - 4'd1))) begin
                        w_state   = ST_LEN;
                        w_sym_cnt = '0;
                        w_asm     = '0;
                    end
                end

                ST_LEN: begin
                    w_asm     = w_asm_full;
                    w_sym_cnt = r_sym_cnt + 2'd1;
                    if (w_last_sym) begin
                        w_len  = w_asm_full;
                        w_csum = '0;
                        w_idx  = '0;
                        if (w_asm_full != 8'd0) begin
                            w_state = ST_PAYLOAD;
                        end else begin
`ifdef QPSK_DEFRAMER_CHK_EN
                            w_state = ST_CHK;
`else
                            w_ok       = 1'b1;
                            w_state    = ST_HUNT;
                            w_hunt_cnt = '0;
`endif
                        end
                    end
                end

                ST_PAYLOAD: begin
                    w_asm     = w_asm_full;
                    w_sym_cnt = r_sym_cnt + 2'd1;
                    if (w_last_sym) begin
                        w_byte = w_asm_full;
                        w_bv   = 1'b1;
                        w_sof  = (r_idx == 8'd0);
                        w_eof  = w_last_byte;
                        w_csum = r_csum ^ w_asm_full;
                        w_idx  = r_idx + 8'd1;
                        if (w_last_byte) begin
`ifdef QPSK_DEFRAMER_CHK_EN
                            w_state = ST_CHK;
`else
                            w_ok       = 1'b1;
                            w_state    = ST_HUNT;
                            w_hunt_cnt = '0;
`endif
                        end
                    end
                end

`ifdef QPSK_DEFRAMER_CHK_EN
                ST_CHK: begin
                    w_asm     = w_asm_full;
                    w_sym_cnt = r_sym_cnt + 2'd1;
                    if (w_last_sym) begin
                        w_ok       = (w_asm_full == r_csum);
                        w_err      = (w_asm_full != r_csum);
                        w_state    = ST_HUNT;
                        w_hunt_cnt = '0;
                    end
                end
`endif

                default: begin
                    w_state    = ST_HUNT;
                    w_hunt_cnt = '0;
                end
            endcase
        end
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_HUNT;
            r_sr_hist  <= '0;
            r_hunt_cnt <= '0;
            r_sym_cnt  <= '0;
            r_asm      <= '0;
            r_idx      <= '0;
            r_csum     <= '0;
            r_byte     <= '0;
            r_bv       <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_len      <= '0;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_sr_hist  <= w_sr_hist;
            r_hunt_cnt <= w_hunt_cnt;
            r_sym_cnt  <= w_sym_cnt;
            r_asm      <= w_asm;
            r_idx      <= w_idx;
            r_csum     <= w_csum;
            r_byte     <= w_byte;
            r_bv       <= w_bv;
            r_sof      <= w_sof;
            r_eof      <= w_eof;
            r_len      <= w_len;
            r_ok       <= w_ok;
            r_err      <= w_err;
        end
    end

    assign byte_o       = r_byte;
    assign byte_valid_o = r_bv;
    assign sof_o        = r_sof;
    assign eof_o        = r_eof;
    assign len_o        = r_len;
    assign locked_o     = (r_state != ST_HUNT);
    assign frame_ok_o   = r_ok;
    assign frame_err_o  = r_err;

endmodule

// File: tb/tb_qpsk_deframer.sv
// Testbench for qpsk_deframer: frames are described at byte level, expanded
// into symbols with the expected output of every sampled cycle attached.
module tb_qpsk_deframer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] data_i;
    logic       sym_valid_i;
    logic [7:0] byte_o;
    logic       byte_valid_o;
    logic       sof_o;
    logic       eof_o;
    logic [7:0] len_o;
    logic       locked_o;
    logic       frame_ok_o;
    logic       frame_err_o;

    qpsk_deframer dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data_i),
        .sym_valid_i  (sym_valid_i),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .sof_o        (sof_o),
        .eof_o        (eof_o),
        .len_o        (len_o),
        .locked_o     (locked_o),
        .frame_ok_o   (frame_ok_o),
        .frame_err_o  (frame_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sym;
        logic       bv, sof, eof, ok, err, locked, lu;
        logic [7:0] b;
    } ev_t;

    ev_t        q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_byte, exp_len;
    logic       exp_locked;
    logic [7:0] pl [0:255];

    task automatic check(input string tag, input logic [21:0] exp);
        logic [21:0] obs;
        obs = {byte_valid_o, sof_o, eof_o, frame_ok_o, frame_err_o, locked_o, byte_o, len_o};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed {bv,sof,eof,ok,err,lock,byte,len}=%h required %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] s, input logic bv, sof, eof, ok, err, locked, lu,
                        input logic [7:0] b);
        ev_t e;
        e.sym = s; e.bv = bv; e.sof = sof; e.eof = eof; e.ok = ok; e.err = err;
        e.locked = locked; e.lu = lu; e.b = b;
        q.push_back(e);
    endtask

    // A byte is four symbols, lowest pair first; events land on the 4th symbol
    task automatic push_byte(input logic [7:0] v, input logic bv, sof, eof, ok, err, locked, lu);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] s;
            s = v[2*k +: 2];
            if (k < 3) push(s, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, v);
            else       push(s, bv, sof, eof, ok, err, locked, lu, v);
        end
    endtask

    task automatic build_frame(input int prefix, input int len, input logic [7:0] cmask);
        logic [15:0] sw;
        logic [7:0]  xr;
        logic [7:0]  c;
        logic        last;
        sw = 16'hD391;
        for (int k = 0; k < prefix; k++)
            push(2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 8; k++)
            push(sw[2*k +: 2], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (k == 7), 1'b0, 8'h00);
`ifdef QPSK_DEFRAMER_CHK_EN
        push_byte(8'(len), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
`else
        push_byte(8'(len), 1'b0, 1'b0, 1'b0, (len == 0), 1'b0, (len != 0), 1'b1);
`endif
        xr = 8'h00;
        for (int i = 0; i < len; i++) begin
            last = (i == len - 1);
            xr   = xr ^ pl[i];
`ifdef QPSK_DEFRAMER_CHK_EN
            push_byte(pl[i], 1'b1, (i == 0), last, 1'b0, 1'b0, 1'b1, 1'b0);
`else
            push_byte(pl[i], 1'b1, (i == 0), last, last, 1'b0, !last, 1'b0);
`endif
        end
`ifdef QPSK_DEFRAMER_CHK_EN
        c = xr ^ cmask;
        push_byte(c, 1'b0, 1'b0, 1'b0, (c == xr), (c != xr), 1'b0, 1'b0);
`else
        c = cmask;
`endif
    endtask

    // mode 0: back-to-back, 1: idle before every symbol, 2: random idles
    task automatic run_q(input string tag, input int mode, input int max_n);
        ev_t e;
        int  g;
        int  n;
        n = 0;
        while (q.size() > 0 && n < max_n) begin
            e = q.pop_front();
            n++;
            g = (mode == 1) ? 1 : (mode == 2) ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0) : 0;
            repeat (g) begin
                sym_valid_i = 1'b0;
                data_i      = 2'($urandom_range(0, 3));
                @(posedge clk); #1;
                check({tag, "_idle"}, {5'b0, exp_locked, exp_byte, exp_len});
            end
            data_i      = e.sym;
            sym_valid_i = 1'b1;
            @(posedge clk); #1;
            if (e.bv) exp_byte = e.b;
            if (e.lu) exp_len  = e.b;
            exp_locked = e.locked;
            check(tag, {e.bv, e.sof, e.eof, e.ok, e.err, e.locked, exp_byte, exp_len});
        end
        sym_valid_i = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        data_i      = 2'd0;
        sym_valid_i = 1'b0;
        exp_byte    = 8'h00;
        exp_len     = 8'h00;
        exp_locked  = 1'b0;
        #12;
        check("reset", 22'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_release", 22'h0);

        // 1: all-zero symbols never lock
        for (int k = 0; k < 20; k++)
            push(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        run_q("zeros", 0, 1000);

        // 2: good two-byte frame
        pl[0] = 8'hA5; pl[1] = 8'h3C;
        build_frame(0, 2, 8'h00);
        run_q("frame_ok", 0, 1000);

        // 3: same frame, checksum off by one bit
        build_frame(0, 2, 8'h01);
        run_q("frame_bad_chk", 0, 1000);

        // 4: empty frame after noise
        build_frame(5, 0, 8'h00);
        run_q("frame_empty", 0, 1000);

        // 5: frame 2 with idle cycles interleaved
        build_frame(0, 2, 8'h00);
        run_q("frame_gapped", 1, 1000);

        // 6: reset after first payload byte (8 sync + 4 length + 4 payload symbols)
        build_frame(0, 2, 8'h00);
        run_q("frame_pre_rst", 0, 16);
        q.delete();
        rst = 1'b1;
        #2;
        exp_byte = 8'h00; exp_len = 8'h00; exp_locked = 1'b0;
        check("async_rst", 22'h0);
        @(posedge clk); #1;
        check("rst_held", 22'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_released", 22'h0);
        build_frame(0, 2, 8'h00);
        run_q("frame_after_rst", 0, 1000);

        // Random frames: lengths incl. boundaries, random corruption and idles
        for (int r = 0; r < 40; r++) begin
            int          len;
            logic [7:0]  cm;
            len = (r == 0) ? 1 : (r == 1) ? 0 : int'($urandom_range(0, 12));
            for (int i = 0; i < len; i++) pl[i] = 8'($urandom_range(0, 255));
            cm = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            build_frame(int'($urandom_range(0, 7)), len, cm);
            run_q("rand_frame", 2, 100000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
